dmi_host_ctrl: RTL and testbench
================================

DMI_HOST_CTRL -- requirements
Module: dmi_host_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, DMI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, DMI data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, timeout limit used only under DMI_TIMEOUT_EN.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rst_n  input  1  async active-low reset.
REQ-007 SHALL have port cmd_valid  input  1  one-cycle pulse on TAP dmi update-DR.
REQ-008 SHALL have ports cmd_addr, cmd_data and cmd_op, all inputs, widths ADDR_WIDTH, DATA_WIDTH and 2, carrying the scanned dmi command fields.
REQ-009 SHALL have port dmi_reset  input  1  pulse that clears the sticky status.
REQ-010 SHALL have port dmi_hard_reset  input  1  pulse that aborts any transaction and clears the sticky status.
REQ-011 SHALL have ports req_addr, req_data, req_op and req_valid, all outputs, widths ADDR_WIDTH, DATA_WIDTH, 2 and 1, forming the DMI request channel (host side).
REQ-012 SHALL have port req_ready  input  1  DMI request accept.
REQ-013 SHALL have ports res_data, res_op and res_valid, all inputs, widths DATA_WIDTH, 2 and 1, forming the DMI response channel.
REQ-014 SHALL have port res_ready  output  1  response accept.
REQ-015 SHALL have ports rsp_data (DATA_WIDTH) and rsp_op (2), both outputs, forming the dmi capture value; rsp_op: 0 = success, 2 = failed, 3 = busy.
REQ-016 SHALL have port busy  output  1  high when the state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, REQ and RSP.
REQ-018 In IDLE, cmd_valid with cmd_op READ(1) or WRITE(2) and rsp_op==0 SHALL latch addr/data/op and go to REQ, with req_valid high the next cycle.
REQ-019 cmd_op NOP(0) or 3 SHALL start no transaction.
REQ-020 While rsp_op!=0 (sticky), commands SHALL be dropped.
REQ-021 In REQ, req_valid, req_addr, req_data and req_op SHALL stay stable until req_valid&&req_ready; the controller SHALL then go to RSP and drop req_valid the next cycle.
REQ-022 res_ready SHALL be 1 in IDLE and RSP and 0 in REQ.
REQ-023 A response arriving in IDLE SHALL be discarded.
REQ-024 In RSP, res_valid SHALL load rsp_data<=res_data, load rsp_op<=0 when res_op==0 and 2 otherwise, and return to IDLE; these updates SHALL be visible, with busy low, one cycle after res_valid.
REQ-025 cmd_valid while busy SHALL drop the command, set rsp_op=3 (sticky), and leave the outstanding transaction undisturbed.
REQ-026 cmd_valid coinciding with res_valid in RSP SHALL set rsp_op=3 and still load rsp_data.
REQ-027 dmi_reset SHALL clear rsp_op to 0 without aborting.
REQ-028 If dmi_reset and cmd_valid coincide in IDLE, the command SHALL be accepted.
REQ-029 dmi_hard_reset SHALL force IDLE, drop req_valid and clear rsp_op.
REQ-030 dmi_hard_reset SHALL take priority over all other events in the same cycle.

Reset
REQ-031 On rst_n low, the controller SHALL enter IDLE with req_valid=0, req_addr=0, req_data=0, req_op=NOP, rsp_data=0, rsp_op=0, busy=0 and res_ready=1.
REQ-032 Reset mid-transaction SHALL abandon the transaction without a response.

Configuration
REQ-033 With DMI_TIMEOUT_EN defined, a counter SHALL clear on entry to REQ and increment each cycle in REQ or RSP.
REQ-034 With DMI_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the controller SHALL go to IDLE, drop req_valid and set rsp_op=2.
REQ-035 With DMI_TIMEOUT_EN defined, completion in the same cycle as the timeout SHALL win.
REQ-036 Without DMI_TIMEOUT_EN, the controller SHALL contain no counter and SHALL wait indefinitely.

Structure
REQ-037 dmi_pkg SHALL hold the dtm_op_type enum (NOP/READ/WRITE), the status constants (SUCCESS=0, FAILED=2, BUSY=3) and the controller state enum.
REQ-038 The timeout counter SHALL be a sub-module, dmi_timeout_ctr, instantiated only under DMI_TIMEOUT_EN.

Verification
REQ-039 The bench SHALL apply READ addr 0x10 with req_ready=1, then res_valid with data 0xDEADBEEF and res_op=0 -> req_valid for 1 cycle, then rsp_data=0xDEADBEEF, rsp_op=0, busy=0 one cycle after res_valid.
REQ-040 The bench SHALL apply WRITE with req_ready held low for 5 cycles -> req_valid high and req_addr/data/op stable for 5 cycles, and a single handshake.
REQ-041 The bench SHALL apply a second cmd_valid during RSP -> rsp_op=3, later commands ignored, and dmi_reset restores acceptance.
REQ-042 The bench SHALL apply res_op=2 -> rsp_op=2, and the next READ is not issued (req_valid stays 0).
REQ-043 The bench SHALL apply dmi_hard_reset during REQ, then a stray res_valid -> IDLE, req_valid=0, response discarded, rsp_op=0.
REQ-044 The bench SHALL build with DMI_TIMEOUT_EN and TIMEOUT_CYCLES=8, with no res_valid -> rsp_op=2 and busy=0 after 8 cycles.

Source files
------------

// File: rtl/dmi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmi_pkg
// Description : Shared types and constants for the DMI host controller:
//               DTM operation encoding, capture status codes, controller state.
// Revision    : 1.0 - initial release
// ============================================================================
package dmi_pkg;

    // Operation field of a scanned dmi command
    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2
    } dtm_op_type;

    // Status reported in the op field of the dmi capture value
    localparam logic [1:0] c_SUCCESS = 2'd0;
    localparam logic [1:0] c_FAILED  = 2'd2;
    localparam logic [1:0] c_BUSY    = 2'd3;

    // Controller state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } ctrl_state_e;

    // True for the two operations that start a bus transaction
    function automatic logic is_xfer_op(input logic [1:0] op);
        return (op == DTM_READ) || (op == DTM_WRITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmi_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : dmi_timeout_ctr
// Description : Transaction watchdog. Cleared when a transaction starts,
//               counts every busy cycle and flags expiry on the cycle in which
//               the count reaches TIMEOUT_CYCLES. Saturates so the flag stays
//               asserted until the controller leaves the busy states.
// Revision    : 1.0 - initial release
// ============================================================================
module dmi_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);

    localparam int              c_CW   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYCLES - 1);

    logic [c_CW-1:0] r_cnt;

    // Count busy cycles, holding at the last value once the limit is hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign o_expire = i_run && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dmi_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmi_host_ctrl
// Description : DTM-side DMI host controller. Turns scanned dmi commands into
//               request/response handshakes on the DMI bus and maintains the
//               sticky capture status (success / failed / busy).
//               Optional feature: define DMI_TIMEOUT_EN to abort transactions
//               that stay busy for TIMEOUT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dmi_host_ctrl
    import dmi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [1:0]            cmd_op,
    input  logic                  dmi_reset,
    input  logic                  dmi_hard_reset,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_data,
    output logic [1:0]            req_op,
    output logic                  req_valid,
    input  logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic [1:0]            res_op,
    input  logic                  res_valid,
    output logic                  res_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_op,
    output logic                  busy
);

    ctrl_state_e           r_state;
    logic                  r_req_valid;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [DATA_WIDTH-1:0] r_req_data;
    logic [1:0]            r_req_op;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [1:0]            r_rsp_op;

    logic [1:0]            w_status_base;
    logic [1:0]            w_status_next;
    logic                  w_accept;
    logic                  w_handshake;
    logic                  w_complete;
    logic                  w_busy_cmd;
    logic                  w_expire;
    logic                  w_abort;

    // A dmi_reset in the same cycle already counts as a clean status, so a
    // coinciding command is judged against the cleared value.
    assign w_status_base = dmi_reset ? c_SUCCESS : r_rsp_op;

    assign w_accept    = (r_state == ST_IDLE) && cmd_valid && is_xfer_op(cmd_op)
                         && (w_status_base == c_SUCCESS);
    assign w_handshake = (r_state == ST_REQ) && r_req_valid && req_ready;
    assign w_complete  = (r_state == ST_RSP) && res_valid;
    assign w_busy_cmd  = (r_state != ST_IDLE) && cmd_valid;
    // A handshake or response in the expiry cycle beats the timeout
    assign w_abort     = w_expire && !w_handshake && !w_complete;

`ifdef DMI_TIMEOUT_EN
    dmi_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_accept),
        .i_run    (r_state != ST_IDLE),
        .o_expire (w_expire)
    );
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_expire         = 1'b0;
`endif

    // Sticky status update: the first error recorded is kept until a reset;
    // a command arriving while busy always reports busy.
    always_comb begin
        w_status_next = w_status_base;
        if (w_status_base == c_SUCCESS) begin
            if (w_complete && (res_op != c_SUCCESS)) begin
                w_status_next = c_FAILED;
            end else if (w_abort) begin
                w_status_next = c_FAILED;
            end
        end
        if (w_busy_cmd) begin
            w_status_next = c_BUSY;
        end
    end

    // Controller state, request channel and capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_req_op    <= DTM_NOP;
            r_rsp_data  <= '0;
            r_rsp_op    <= c_SUCCESS;
        end else if (dmi_hard_reset) begin
            r_state     <= ST_IDLE;
            r_req_valid <= 1'b0;
            r_rsp_op    <= c_SUCCESS;
        end else begin
            r_rsp_op <= w_status_next;
            if (w_complete) begin
                r_rsp_data <= res_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= cmd_addr;
                        r_req_data  <= cmd_data;
                        r_req_op    <= cmd_op;
                    end
                end
                ST_REQ: begin
                    if (w_handshake) begin
                        r_state     <= ST_RSP;
                        r_req_valid <= 1'b0;
                    end else if (w_abort) begin
                        r_state     <= ST_IDLE;
                        r_req_valid <= 1'b0;
                    end
                end
                ST_RSP: begin
                    if (w_complete || w_abort) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid = r_req_valid;
    assign req_addr  = r_req_addr;
    assign req_data  = r_req_data;
    assign req_op    = r_req_op;
    assign rsp_data  = r_rsp_data;
    assign rsp_op    = r_rsp_op;
    assign busy      = (r_state != ST_IDLE);
    assign res_ready = (r_state != ST_REQ);

endmodule
`default_nettype wire

// File: tb/tb_dmi_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmi_host_ctrl
// Description : Self-checking bench for dmi_host_ctrl: directed scenarios with
//               literal expectations, then randomized traffic compared every
//               cycle against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmi_host_ctrl;

    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic [1:0]    cmd_op = 2'd0;
    logic          dmi_reset = 1'b0;
    logic          dmi_hard_reset = 1'b0;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [1:0]    req_op;
    logic          req_valid;
    logic          req_ready = 1'b0;
    logic [DW-1:0] res_data = '0;
    logic [1:0]    res_op = 2'd0;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_op;
    logic          busy;

    always #5 clk = ~clk;

    dmi_host_ctrl #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .cmd_op         (cmd_op),
        .dmi_reset      (dmi_reset),
        .dmi_hard_reset (dmi_hard_reset),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_op         (req_op),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .res_data       (res_data),
        .res_op         (res_op),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .rsp_data       (rsp_data),
        .rsp_op         (rsp_op),
        .busy           (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: one outstanding transaction, described as
    // "in flight" plus "request already handed off", with a sticky status.
    // ------------------------------------------------------------------
    bit          m_busy   = 1'b0;
    bit          m_issued = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]  m_op     = 2'd0;
    logic [1:0]  m_status = 2'd0;
    int          m_age    = 0;

    initial begin
        logic [1:0] st;
        bit         moved;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_issued = 0; m_addr = '0; m_data = '0;
                m_op = 2'd0; m_rdata = '0; m_status = 2'd0; m_age = 0;
            end else if (dmi_hard_reset) begin
                m_busy = 0; m_issued = 0; m_status = 2'd0;
            end else begin
                st = dmi_reset ? 2'd0 : m_status;
                if (!m_busy) begin
                    if (cmd_valid && (cmd_op == 2'd1 || cmd_op == 2'd2) && st == 2'd0) begin
                        m_busy = 1; m_issued = 0; m_age = 0;
                        m_addr = cmd_addr; m_data = cmd_data; m_op = cmd_op;
                    end
                end else begin
                    m_age++;
                    moved = 0;
                    if (!m_issued) begin
                        if (req_ready) begin
                            m_issued = 1;
                            moved = 1;
                        end
                    end else if (res_valid) begin
                        m_rdata = res_data;
                        if (st == 2'd0 && res_op != 2'd0) st = 2'd2;
                        m_busy = 0; m_issued = 0;
                        moved = 1;
                    end
`ifdef DMI_TIMEOUT_EN
                    if (!moved && m_age >= TMO) begin
                        m_busy = 0; m_issued = 0;
                        if (st == 2'd0) st = 2'd2;
                    end
`endif
                    if (cmd_valid) st = 2'd3;
                end
                m_status = st;
            end
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            chk("req_valid", 64'(req_valid), 64'(m_busy && !m_issued));
            chk("busy",      64'(busy),      64'(m_busy));
            chk("res_ready", 64'(res_ready), 64'(!(m_busy && !m_issued)));
            chk("req_addr",  64'(req_addr),  64'(m_addr));
            chk("req_data",  64'(req_data),  64'(m_data));
            chk("req_op",    64'(req_op),    64'(m_op));
            chk("rsp_data",  64'(rsp_data),  64'(m_rdata));
            chk("rsp_op",    64'(rsp_op),    64'(m_status));
            if (req_valid && req_ready) hs_cnt++;
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cmd_valid = 0; dmi_reset = 0; dmi_hard_reset = 0; res_valid = 0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1; cmd_op = op; cmd_addr = a; cmd_data = d;
    endtask

    initial begin
        int hs0;
        int cnt;

        // Reset values
        repeat (3) tick();
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_req_valid", 64'(req_valid), 64'(0));
        chk("rst_res_ready", 64'(res_ready), 64'(1));
        chk("rst_rsp_op",    64'(rsp_op),    64'(0));
        chk("rst_rsp_data",  64'(rsp_data),  64'(0));
        chk("rst_req_op",    64'(req_op),    64'(0));
        rst_n = 1;
        tick();

        // READ 0x10, immediate accept, successful response
        req_ready = 1;
        send_cmd(2'd1, 7'h10, 32'h0);
        tick(); quiet();
        chk("rd_req_valid", 64'(req_valid), 64'(1));
        chk("rd_req_addr",  64'(req_addr),  64'(7'h10));
        chk("rd_req_op",    64'(req_op),    64'(1));
        chk("rd_res_ready_in_req", 64'(res_ready), 64'(0));
        tick();
        chk("rd_req_valid_drop", 64'(req_valid), 64'(0));
        chk("rd_busy_rsp",       64'(busy),      64'(1));
        res_valid = 1; res_data = 32'hDEADBEEF; res_op = 2'd0;
        tick(); quiet();
        chk("rd_rsp_data", 64'(rsp_data), 64'(32'hDEADBEEF));
        chk("rd_rsp_op",   64'(rsp_op),   64'(0));
        chk("rd_busy_done", 64'(busy),    64'(0));
        chk("model_rdata", 64'(m_rdata),  64'(32'hDEADBEEF));

        // WRITE with req_ready low for 5 cycles
        req_ready = 0;
        hs0 = hs_cnt;
        send_cmd(2'd2, 7'h22, 32'h12345678);
        tick(); quiet();
        for (int k = 0; k < 5; k++) begin
            chk("wr_hold_valid", 64'(req_valid), 64'(1));
            chk("wr_hold_addr",  64'(req_addr),  64'(7'h22));
            chk("wr_hold_data",  64'(req_data),  64'(32'h12345678));
            chk("wr_hold_op",    64'(req_op),    64'(2));
            tick();
        end
        req_ready = 1;
        tick();
        chk("wr_valid_drop", 64'(req_valid), 64'(0));
        res_valid = 1; res_data = 32'h0; res_op = 2'd0;
        tick(); quiet();
        chk("wr_single_handshake", 64'(hs_cnt - hs0), 64'(1));
        chk("wr_busy_done", 64'(busy), 64'(0));

        // Command colliding with the response -> busy status, then blocked
        send_cmd(2'd1, 7'h05, 32'h0);
        tick(); quiet();
        tick();
        send_cmd(2'd1, 7'h06, 32'h0);
        res_valid = 1; res_data = 32'hCAFE0001; res_op = 2'd0;
        tick(); quiet();
        chk("col_rsp_op",   64'(rsp_op),   64'(3));
        chk("col_rsp_data", 64'(rsp_data), 64'(32'hCAFE0001));
        chk("col_busy",     64'(busy),     64'(0));
        send_cmd(2'd1, 7'h07, 32'h0);
        tick(); quiet();
        chk("sticky_blocks_valid", 64'(req_valid), 64'(0));
        chk("sticky_rsp_op",       64'(rsp_op),    64'(3));
        dmi_reset = 1;
        send_cmd(2'd1, 7'h33, 32'h0);
        tick(); quiet();
        chk("dmireset_accept_busy", 64'(busy),     64'(1));
        chk("dmireset_accept_addr", 64'(req_addr), 64'(7'h33));
        chk("dmireset_rsp_op",      64'(rsp_op),   64'(0));
        tick();
        res_valid = 1; res_data = 32'h0; res_op = 2'd0;
        tick(); quiet();

        // Failed response, next READ not issued
        send_cmd(2'd1, 7'h08, 32'h0);
        tick(); quiet();
        tick();
        res_valid = 1; res_data = 32'h11112222; res_op = 2'd2;
        tick(); quiet();
        chk("fail_rsp_op",   64'(rsp_op),   64'(2));
        chk("fail_rsp_data", 64'(rsp_data), 64'(32'h11112222));
        send_cmd(2'd1, 7'h09, 32'h0);
        tick(); quiet();
        chk("fail_blocks_valid", 64'(req_valid), 64'(0));
        tick();
        chk("fail_blocks_busy",  64'(busy),      64'(0));
        dmi_reset = 1;
        tick(); quiet();
        chk("fail_cleared", 64'(rsp_op), 64'(0));

        // Hard reset during REQ, then stray response
        req_ready = 0;
        send_cmd(2'd2, 7'h0A, 32'h55);
        tick(); quiet();
        send_cmd(2'd1, 7'h0B, 32'h0);
        tick(); quiet();
        chk("hr_pre_busy_status", 64'(rsp_op), 64'(3));
        dmi_hard_reset = 1;
        send_cmd(2'd1, 7'h0C, 32'h0);
        tick(); quiet();
        chk("hr_busy",      64'(busy),      64'(0));
        chk("hr_req_valid", 64'(req_valid), 64'(0));
        chk("hr_rsp_op",    64'(rsp_op),    64'(0));
        res_valid = 1; res_data = 32'h0BAD0BAD; res_op = 2'd0;
        tick(); quiet();
        chk("stray_rsp_data", 64'(rsp_data), 64'(32'h11112222));
        chk("stray_busy",     64'(busy),     64'(0));

`ifdef DMI_TIMEOUT_EN
        // No response at all -> timeout after TMO busy cycles
        send_cmd(2'd1, 7'h0D, 32'h0);
        tick(); quiet();
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("tmo_busy_cycles", 64'(cnt),       64'(TMO));
        chk("tmo_rsp_op",      64'(rsp_op),    64'(2));
        chk("tmo_req_valid",   64'(req_valid), 64'(0));
        dmi_reset = 1;
        tick(); quiet();
`endif

        // Randomized traffic, checked every cycle by the model comparison
        for (int i = 0; i < 3000; i++) begin
            cmd_valid      = ($urandom_range(0, 5) == 0);
            cmd_op         = 2'($urandom_range(0, 3));
            cmd_addr       = AW'($urandom);
            cmd_data       = $urandom;
            dmi_reset      = ($urandom_range(0, 14) == 0);
            dmi_hard_reset = ($urandom_range(0, 59) == 0);
            req_ready      = ($urandom_range(0, 1) == 1);
            res_valid      = ($urandom_range(0, 4) < 2);
            res_data       = $urandom;
            res_op         = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            tick();
        end
        quiet();
        dmi_hard_reset = 1;
        tick(); quiet();

        // Reset in the middle of a transaction
        req_ready = 0;
        send_cmd(2'd1, 7'h44, 32'h0);
        tick(); quiet();
        chk("mid_pre_busy", 64'(busy), 64'(1));
        #3 rst_n = 0;
        #1;
        chk("mid_rst_busy",      64'(busy),      64'(0));
        chk("mid_rst_req_valid", 64'(req_valid), 64'(0));
        chk("mid_rst_req_addr",  64'(req_addr),  64'(0));
        chk("mid_rst_rsp_data",  64'(rsp_data),  64'(0));
        chk("mid_rst_res_ready", 64'(res_ready), 64'(1));
        tick();
        rst_n = 1;
        res_valid = 1; res_data = 32'h77;
        tick(); quiet();
        chk("mid_after_rsp_data", 64'(rsp_data), 64'(0));
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
